dac_spi_ctrl: RTL and testbench

DAC_SPI_CTRL -- requirements
Module: dac_spi_ctrl

---
 rtl/dac_spi_ctrl_if.sv | 23 ++
 rtl/dac_spi_ctrl.sv | 129 ++++++++++++
 tb/tb_dac_spi_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/dac_spi_ctrl_if.sv
// Sample request and DAC serial pins for dac_spi_ctrl.
// The master drives start/data_in. The controller drives the DAC pins, the status pulses and the debug state.
interface dac_spi_ctrl_if;
  logic        start;
  logic [11:0] data_in;
  logic        sync_n;
  logic        sclk;
  logic        sdata;
  logic        busy;
  logic        done_tick;
  logic        overrun;
  logic [1:0]  dbg_state;

  modport master (
    output start, data_in,
    input  sync_n, sclk, sdata, busy, done_tick, overrun, dbg_state
  );

  modport slave (
    input  start, data_in,
    output sync_n, sclk, sdata, busy, done_tick, overrun, dbg_state
  );
endinterface

// File: rtl/dac_spi_ctrl.sv
// Serialises one 12-bit signed sample per start into a 16-bit DAC frame.
// The frame is two mode bits (00), two zero bits and the sample in offset binary, sent MSB first.
module dac_spi_ctrl #(
  parameter int unsigned DIV     = 2,
  parameter int unsigned GAP_CYC = 4
) (
  input logic           clk,
  input logic           reset,
  dac_spi_ctrl_if.slave bus
);

  // Handshake: start is sampled on each clk edge. It is accepted only when busy is low.
  // A start that arrives while busy is high is dropped and reported with a one-cycle overrun pulse.
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, GAP = 2'd2} state_e;

  localparam logic [7:0] DIV_LAST = 8'(DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYC - 1);

  state_e      state_q, state_d;
  logic [15:0] shift_q, shift_d;
  logic [7:0]  div_cnt_q, div_cnt_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  gap_cnt_q, gap_cnt_d;
  logic        sclk_q, sclk_d;
  logic        sync_n_q, sync_n_d;
  logic        sdata_q, sdata_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        ovr_q, ovr_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      sclk_q    <= 1'b1;
      sync_n_q  <= 1'b1;
      sdata_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      sclk_q    <= sclk_d;
      sync_n_q  <= sync_n_d;
      sdata_q   <= sdata_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ovr_q     <= ovr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    sclk_d    = sclk_q;
    sync_n_d  = sync_n_q;
    ovr_d     = 1'b0;

    case (state_q)
      IDLE: begin
        sclk_d   = 1'b1;
        sync_n_d = 1'b1;
        if (bus.start) begin
          shift_d   = {4'b0000, ~bus.data_in[11], bus.data_in[10:0]};
          div_cnt_d = '0;
          bit_cnt_d = '0;
          sync_n_d  = 1'b0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        ovr_d = bus.start;
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          sclk_d    = ~sclk_q;
          // Data is held on the falling edge, where the DAC samples, and advances on the rising edge.
          if (!sclk_q) begin
            shift_d   = {shift_q[14:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd15) begin
              sync_n_d  = 1'b1;
              gap_cnt_d = '0;
              state_d   = GAP;
            end
          end
        end else begin
          div_cnt_d = div_cnt_q + 8'd1;
        end
      end
      GAP: begin
        ovr_d = bus.start;
        if (gap_cnt_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d  = IDLE;
        sclk_d   = 1'b1;
        sync_n_d = 1'b1;
      end
    endcase

    // Outputs are registered, so they are derived from the upcoming state.
    sdata_d = (state_d == SHIFT) ? shift_d[15] : 1'b0;
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == GAP) && (gap_cnt_d == GAP_LAST);
  end

  assign bus.sync_n    = sync_n_q;
  assign bus.sclk      = sclk_q;
  assign bus.sdata     = sdata_q;
  assign bus.busy      = busy_q;
  assign bus.done_tick = done_q;
  assign bus.overrun   = ovr_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_dac_spi_ctrl.sv
// Directed and random frames checked against a timing/arithmetic model of the DAC frame.
// Two instances are used: DIV=2/GAP_CYC=4 and DIV=1/GAP_CYC=1.
module tb_dac_spi_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dac_spi_ctrl_if if_a ();
  dac_spi_ctrl_if if_b ();

  int          sel = 0;
  logic        st = 1'b0;
  logic [11:0] dat = '0;

  assign if_a.start   = (sel == 0) ? st : 1'b0;
  assign if_a.data_in = dat;
  assign if_b.start   = (sel == 1) ? st : 1'b0;
  assign if_b.data_in = dat;

  dac_spi_ctrl #(.DIV(2), .GAP_CYC(4)) u_dut_a (.clk(clk), .reset(reset), .bus(if_a));
  dac_spi_ctrl #(.DIV(1), .GAP_CYC(1)) u_dut_b (.clk(clk), .reset(reset), .bus(if_b));

  logic o_sync_n, o_sclk, o_sdata, o_busy, o_done, o_ovr;
  assign o_sync_n = (sel == 1) ? if_b.sync_n    : if_a.sync_n;
  assign o_sclk   = (sel == 1) ? if_b.sclk      : if_a.sclk;
  assign o_sdata  = (sel == 1) ? if_b.sdata     : if_a.sdata;
  assign o_busy   = (sel == 1) ? if_b.busy      : if_a.busy;
  assign o_done   = (sel == 1) ? if_b.done_tick : if_a.done_tick;
  assign o_ovr    = (sel == 1) ? if_b.overrun   : if_a.overrun;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offset binary is the signed sample plus half scale; mode bits are zero.
  function automatic logic [15:0] model(input logic [11:0] d);
    int v;
    v = (int'(d) + 2048) % 4096;
    return 16'(v);
  endfunction

  // Called just after a negedge while idle; start is sampled at the next edge (edge 0).
  // Cycle k is observed at the negedge following edge k-1.
  task automatic run_frame(input int div, input int gap, input logic [11:0] d,
                           input logic [15:0] exp_word, input int ovr_cyc);
    int          shift_len;
    int          total;
    int          nfall;
    logic [15:0] word;
    logic        prev_sclk;
    shift_len = 32 * div;
    total     = shift_len + gap + 1;
    nfall     = 0;
    word      = '0;
    chk("idle_sync_n", 32'(o_sync_n), 32'd1);
    chk("idle_sclk", 32'(o_sclk), 32'd1);
    chk("idle_sdata", 32'(o_sdata), 32'd0);
    chk("idle_busy", 32'(o_busy), 32'd0);
    exp_q.push_back(exp_word);
    st = 1'b1;
    dat = d;
    prev_sclk = o_sclk;
    for (int k = 1; k <= total; k++) begin
      @(negedge clk);
      chk("sync_n", 32'(o_sync_n), (k <= shift_len) ? 32'd0 : 32'd1);
      chk("sclk", 32'(o_sclk), (k <= shift_len) ? 32'((((k - 1) / div) % 2) == 0) : 32'd1);
      chk("busy", 32'(o_busy), 32'(k <= shift_len + gap));
      chk("done_tick", 32'(o_done), 32'(k == shift_len + gap));
      chk("overrun", 32'(o_ovr), 32'(k == ovr_cyc + 1));
      if (k > shift_len) chk("gap_sdata", 32'(o_sdata), 32'd0);
      if (prev_sclk && !o_sclk) begin
        word = {word[14:0], o_sdata};
        nfall++;
      end
      prev_sclk = o_sclk;
      st  = (k == ovr_cyc);
      dat = 12'($urandom_range(0, 4095));
    end
    chk("sclk_falls", 32'(nfall), 32'd16);
    chk("frame_bits", 32'(word), 32'(exp_q.pop_front()));
  endtask

  initial begin
    int          starts[$];
    int          hi_run;
    logic        prev_busy, prev_sync;
    logic [11:0] d;
    bit          idle_seen;

    repeat (3) @(negedge clk);
    chk("rst_sync_n", 32'(o_sync_n), 32'd1);
    chk("rst_sclk", 32'(o_sclk), 32'd1);
    chk("rst_sdata", 32'(o_sdata), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_ovr", 32'(o_ovr), 32'd0);

    // First edge after reset release must accept; directed frames run back-to-back.
    reset = 1'b0;
    run_frame(2, 4, 12'h7FF, 16'h0FFF, -1);
    run_frame(2, 4, 12'h800, 16'h0000, -1);
    run_frame(2, 4, 12'h000, 16'h0800, -1);
    run_frame(2, 4, 12'hFFF, 16'h07FF, -1);

    for (int i = 0; i < 3; i++) begin
      d = 12'($urandom);
      run_frame(2, 4, d, model(d), -1);
    end
    d = 12'($urandom);
    run_frame(2, 4, d, model(d), 20);
    d = 12'($urandom);
    run_frame(2, 4, d, model(d), 68);

    // Start held high: frames repeat every 69 cycles, rejected starts pulse overrun.
    st = 1'b1;
    dat = 12'($urandom);
    prev_busy = 1'b0;
    prev_sync = 1'b1;
    hi_run = 0;
    for (int k = 1; k <= 208; k++) begin
      @(negedge clk);
      chk("cont_overrun", 32'(o_ovr), 32'(prev_busy));
      if (prev_sync && !o_sync_n) begin
        if (starts.size() > 0) chk("cont_sync_hi_len", 32'(hi_run >= 4), 32'd1);
        starts.push_back(k);
      end
      hi_run = o_sync_n ? hi_run + 1 : 0;
      prev_busy = o_busy;
      prev_sync = o_sync_n;
      dat = 12'($urandom);
    end
    st = 1'b0;
    chk("cont_frames", 32'(starts.size()), 32'd4);
    for (int i = 1; i < starts.size(); i++)
      chk("cont_period", 32'(starts[i] - starts[i-1]), 32'd69);
    idle_seen = 1'b0;
    for (int k = 0; k < 200 && !idle_seen; k++) begin
      @(negedge clk);
      idle_seen = !o_busy;
    end
    chk("cont_drain", 32'(idle_seen), 32'd1);
    @(negedge clk);

    // Reset in the middle of a frame.
    st = 1'b1;
    dat = 12'($urandom);
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      st = 1'b0;
    end
    reset = 1'b1;
    #1;
    chk("midrst_sync_n", 32'(o_sync_n), 32'd1);
    chk("midrst_sclk", 32'(o_sclk), 32'd1);
    chk("midrst_busy", 32'(o_busy), 32'd0);
    chk("midrst_sdata", 32'(o_sdata), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("midrst_no_done", 32'(o_done), 32'd0);
    end
    reset = 1'b0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      chk("postrst_no_done", 32'(o_done), 32'd0);
      chk("postrst_idle", 32'(o_busy), 32'd0);
    end
    d = 12'($urandom);
    run_frame(2, 4, d, model(d), -1);

    // DIV=1, GAP_CYC=1 instance.
    @(negedge clk);
    sel = 1;
    #1;
    d = 12'($urandom);
    run_frame(1, 1, d, model(d), -1);
    d = 12'($urandom);
    run_frame(1, 1, d, model(d), 10);
    d = 12'($urandom);
    run_frame(1, 1, d, model(d), 33);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
